pingpong_vec_buf: RTL and testbench
===================================

// Module: pingpong_vec_buf
// PURPOSE
//  Parametrised double-buffered (ping/pong) vector staging buffer for the ID stage.
//  Producer writes LANES words per beat. GROUPS beats fill one frame. Consumer sees the whole frame in parallel.
//  Two frame banks let the producer fill one bank while the consumer holds the other.
//  Bank switching is fully synchronous and driven by the handshakes.
// PARAMETERS
//  WIDTH   32  bits per word
//  LANES   4   words written per accepted beat (>=1)
//  GROUPS  2   beats per frame (>=1); frame = GROUPS*LANES words
//  CNT_W   16  width of frame_cnt
// PORTS
//  clk        in   1                    clock, all state on posedge
//  rst_n      in   1                    asynchronous active-low reset
//  wr_valid   in   1                    producer beat valid
//  wr_ready   out  1                    buffer can accept a beat
//  wr_data    in   LANES*WIDTH          lane i at [i*WIDTH +: WIDTH]
//  wr_grp     out  $clog2(GROUPS)|1     group index the next beat fills
//  rd_valid   out  1                    complete frame presented
//  rd_ready   in   1                    consumer releases frame
//  rd_data    out  GROUPS*LANES*WIDTH   word k=g*LANES+i at [k*WIDTH +: WIDTH]
//  frame_cnt  out  CNT_W                frames completed by writer, wraps
//  flush      in   1                    only when PINGPONG_VEC_BUF_FLUSH_EN defined
// BEHAVIOUR
//  State: wr_bank, rd_bank (1b each), full[1:0], grp_cnt, frame_cnt.
//  Reset: all state is 0, so wr_ready=1, rd_valid=0, wr_grp=0, frame_cnt=0.
//  Storage is not reset. rd_data is don't-care while rd_valid=0.
//  wr_ready = !full[wr_bank], a combinational function of state only. It does not depend on wr_valid.
//  Write beat (wr_valid&wr_ready):
//  - store word (grp_cnt*LANES+i) of wr_bank <= lane i.
//  - if grp_cnt==GROUPS-1: grp_cnt<=0, full[wr_bank]<=1, wr_bank toggles, frame_cnt++.
//  - otherwise grp_cnt++.
//  rd_valid = full[rd_bank]. rd_data is a combinational view of bank rd_bank.
//  rd_data stays stable while rd_valid&!rd_ready.
//  Read handshake (rd_valid&rd_ready): full[rd_bank]<=0, rd_bank toggles.
//  Latency: last beat accepted at edge N gives rd_valid=1 after edge N, if that bank is rd_bank.
//  Simultaneous frame completion and read release on different banks: both take effect at the same edge.
//  The same bank can never be written and read together, because writes require !full.
//  Both banks full: wr_ready=0 and wr_data is ignored. No data is lost and there is no overflow.
//  GROUPS=1: every accepted beat completes a frame.
//  frame_cnt wraps 2^CNT_W-1 -> 0.
//  Reset mid-frame: partial frame discarded, both banks empty, pointers back to bank 0.
// CONFIGURATION
//  PINGPONG_VEC_BUF_FLUSH_EN defined:
//  - flush port present. Flush high at an edge sets grp_cnt<=0.
//  - The partial frame in wr_bank is abandoned and not marked full. full[], rd_bank and frame_cnt are unchanged.
//  - wr_ready is forced 0 while flush=1, so no beat can be lost.
//  - A read handshake in the same cycle still completes.
//  Not defined: port absent. A partial frame persists until its remaining beats arrive.
// STRUCTURE
//  Package pingpong_vec_buf_pkg:
//  - default WIDTH/LANES/GROUPS/CNT_W constants.
//  - typedef bank_sel_t (1b).
//  - function word_idx(grp, lane) returning grp*LANES+lane.
//  Sub-module pingpong_vec_bank:
//  - one frame of storage with a group-write port (we, grp, data) and a flattened parallel read.
//  - instantiated twice; the top level holds the pointers, full[] and the handshake logic.
// TESTING
//  1 Reset, then 2 beats of {1,2,3,4} and {5,6,7,8} with rd_ready=0 -> rd_valid=1 one edge after beat 2.
//    rd_data words 0..7 = 1..8; frame_cnt=1; wr_grp=0; wr_ready=1.
//  2 Fill a second frame (9..16) while frame 1 is held -> wr_ready=0 after its last beat.
//    rd_ready=1 for 1 cycle -> rd_data shows 9..16 and wr_ready returns to 1.
//  3 Beat 2 of frame 3 and a rd_ready handshake in the same cycle -> both banks update.
//    rd_valid remains 1 with the next frame; no data corruption.
//  4 GROUPS=1, LANES=8: 3 back-to-back beats with rd_ready=1 held -> 3 frames in order, frame_cnt=3, no stall.
//  5 rst_n low for 1 cycle mid-frame (grp_cnt=1) with bank 1 full -> rd_valid=0, wr_ready=1, wr_grp=0, frame_cnt=0.
//  6 FLUSH_EN: 1 beat, then flush, then 2 beats {A..H} -> frame contains A..H only, and wr_ready=0 during flush.

Source files
------------

// File: rtl/pingpong_vec_buf_pkg.sv
// Shared constants, types and helpers for the ping/pong vector staging buffer.
package pingpong_vec_buf_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_LANES  = 4;
    localparam int unsigned DEF_GROUPS = 2;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef logic bank_sel_t;

    // Flat word index of lane `lane` within beat group `grp`.
    function automatic int unsigned word_idx(input int unsigned grp, input int unsigned lane,
                                             input int unsigned lanes = DEF_LANES);
        return grp * lanes + lane;
    endfunction

endpackage

// File: rtl/pingpong_vec_bank.sv
// One frame of storage: a group-wide write port and a flattened parallel read.
module pingpong_vec_bank
    import pingpong_vec_buf_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned GROUPS = DEF_GROUPS,
    parameter int unsigned GRP_W  = 1
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [GRP_W-1:0]                grp,
    input  logic [LANES*WIDTH-1:0]          data,
    output logic [GROUPS*LANES*WIDTH-1:0]   rd_data
);

    logic [GROUPS*LANES*WIDTH-1:0] mem_q;

    // Storage is intentionally not reset; contents only matter once a frame is complete.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int g = 0; g < int'(GROUPS); g++) begin
                if (grp == GRP_W'(g)) begin
                    for (int i = 0; i < int'(LANES); i++) begin
                        mem_q[word_idx(g, i, LANES)*WIDTH +: WIDTH] <= data[i*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    assign rd_data = mem_q;

endmodule

// File: rtl/pingpong_vec_buf.sv
// Double-buffered vector staging buffer: producer fills one bank while consumer holds the other.
// Optional flush port enabled by defining PINGPONG_VEC_BUF_FLUSH_EN.
module pingpong_vec_buf
    import pingpong_vec_buf_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned LANES  = DEF_LANES,
    parameter int unsigned GROUPS = DEF_GROUPS,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    localparam int unsigned GRP_W = $clog2(GROUPS) | 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [LANES*WIDTH-1:0]          wr_data,
    output logic [GRP_W-1:0]                wr_grp,
    output logic                            rd_valid,
    input  logic                            rd_ready,
    output logic [GROUPS*LANES*WIDTH-1:0]   rd_data,
    output logic [CNT_W-1:0]                frame_cnt
`ifdef PINGPONG_VEC_BUF_FLUSH_EN
   ,input  logic                            flush
`endif
);

    localparam int unsigned FRAME_W = GROUPS * LANES * WIDTH;

    bank_sel_t          wr_bank_q, wr_bank_d;
    bank_sel_t          rd_bank_q, rd_bank_d;
    logic [1:0]         full_q, full_d;
    logic [GRP_W-1:0]   grp_cnt_q, grp_cnt_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;

    logic               flush_act;
    logic               wr_fire, rd_fire, last_beat;
    logic [FRAME_W-1:0] bank_data [2];

`ifdef PINGPONG_VEC_BUF_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    assign wr_ready  = !full_q[wr_bank_q] && !flush_act;
    assign rd_valid  = full_q[rd_bank_q];
    assign wr_fire   = wr_valid && wr_ready;
    assign rd_fire   = rd_valid && rd_ready;
    assign last_beat = (grp_cnt_q == GRP_W'(GROUPS - 1));

    always_comb begin
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        grp_cnt_d   = grp_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (rd_fire) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        // A write never targets a full bank, so it cannot collide with the release above.
        if (wr_fire) begin
            if (last_beat) begin
                grp_cnt_d         = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                frame_cnt_d       = frame_cnt_q + CNT_W'(1);
            end else begin
                grp_cnt_d = grp_cnt_q + GRP_W'(1);
            end
        end
        if (flush_act) begin
            grp_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q   <= '0;
            rd_bank_q   <= '0;
            full_q      <= '0;
            grp_cnt_q   <= '0;
            frame_cnt_q <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            grp_cnt_q   <= grp_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    pingpong_vec_bank #(
        .WIDTH  (WIDTH),
        .LANES  (LANES),
        .GROUPS (GROUPS),
        .GRP_W  (GRP_W)
    ) u_bank0 (
        .clk     (clk),
        .we      (wr_fire && (wr_bank_q == 1'b0)),
        .grp     (grp_cnt_q),
        .data    (wr_data),
        .rd_data (bank_data[0])
    );

    pingpong_vec_bank #(
        .WIDTH  (WIDTH),
        .LANES  (LANES),
        .GROUPS (GROUPS),
        .GRP_W  (GRP_W)
    ) u_bank1 (
        .clk     (clk),
        .we      (wr_fire && (wr_bank_q == 1'b1)),
        .grp     (grp_cnt_q),
        .data    (wr_data),
        .rd_data (bank_data[1])
    );

    assign rd_data   = rd_bank_q ? bank_data[1] : bank_data[0];
    assign wr_grp    = grp_cnt_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_pingpong_vec_buf.sv
// Self-checking bench: default-config DUT (4 lanes x 2 groups) and a 8-lane, 1-group, 2-bit-count DUT.
module tb_pingpong_vec_buf;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         wr_valid_a = 1'b0, rd_ready_a = 1'b0, flush_a = 1'b0;
    logic [127:0] wr_data_a = '0;
    logic         wr_ready_a, rd_valid_a;
    logic [0:0]   wr_grp_a;
    logic [255:0] rd_data_a;
    logic [15:0]  frame_cnt_a;

    logic         wr_valid_b = 1'b0, rd_ready_b = 1'b0, flush_b = 1'b0;
    logic [255:0] wr_data_b = '0;
    logic         wr_ready_b, rd_valid_b;
    logic [0:0]   wr_grp_b;
    logic [255:0] rd_data_b;
    logic [1:0]   frame_cnt_b;

    pingpong_vec_buf dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid_a),
        .wr_ready  (wr_ready_a),
        .wr_data   (wr_data_a),
        .wr_grp    (wr_grp_a),
        .rd_valid  (rd_valid_a),
        .rd_ready  (rd_ready_a),
        .rd_data   (rd_data_a),
        .frame_cnt (frame_cnt_a)
`ifdef PINGPONG_VEC_BUF_FLUSH_EN
       ,.flush     (flush_a)
`endif
    );

    pingpong_vec_buf #(
        .WIDTH  (32),
        .LANES  (8),
        .GROUPS (1),
        .CNT_W  (2)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid_b),
        .wr_ready  (wr_ready_b),
        .wr_data   (wr_data_b),
        .wr_grp    (wr_grp_b),
        .rd_valid  (rd_valid_b),
        .rd_ready  (rd_ready_b),
        .rd_data   (rd_data_b),
        .frame_cnt (frame_cnt_b)
`ifdef PINGPONG_VEC_BUF_FLUSH_EN
       ,.flush     (flush_b)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two complete frames plus the frame being assembled.
    logic [255:0] mfr [2][2];
    logic [255:0] mpart [2];
    int mcnt [2] = '{0, 0};
    int mgrp [2] = '{0, 0};
    int mfc  [2] = '{0, 0};
    int ml   [2] = '{4, 8};
    int mg   [2] = '{2, 1};
    int mmask[2] = '{32'hFFFF, 3};

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            mcnt[d] = 0;
            mgrp[d] = 0;
            mfc[d]  = 0;
        end
    endtask

    task automatic mstep(input int d, input logic wv, input logic [255:0] wd,
                         input logic rr, input logic fl);
        logic rfire, wfire;
        rfire = (mcnt[d] > 0) && rr;
        wfire = wv && (mcnt[d] < 2) && !fl;
        if (rfire) begin
            mfr[d][0] = mfr[d][1];
            mcnt[d]--;
        end
        if (wfire) begin
            for (int i = 0; i < ml[d]; i++)
                mpart[d][(mgrp[d]*ml[d]+i)*32 +: 32] = wd[i*32 +: 32];
            if (mgrp[d] == mg[d] - 1) begin
                mfr[d][mcnt[d]] = mpart[d];
                mcnt[d]++;
                mgrp[d] = 0;
                mfc[d]  = (mfc[d] + 1) & mmask[d];
            end else begin
                mgrp[d]++;
            end
        end
        if (fl) mgrp[d] = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mreset();
            end else begin
                mstep(0, wr_valid_a, {128'b0, wr_data_a}, rd_ready_a, flush_a);
                mstep(1, wr_valid_b, wr_data_b, rd_ready_b, flush_b);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("a_wr_ready", wr_ready_a, (mcnt[0] < 2) && !flush_a);
            chk("a_rd_valid", rd_valid_a, mcnt[0] > 0);
            chk("a_wr_grp", wr_grp_a, mgrp[0]);
            chk("a_frame_cnt", frame_cnt_a, mfc[0]);
            if (mcnt[0] > 0) chk("a_rd_data", rd_data_a, mfr[0][0]);
            chk("b_wr_ready", wr_ready_b, (mcnt[1] < 2) && !flush_b);
            chk("b_rd_valid", rd_valid_b, mcnt[1] > 0);
            chk("b_wr_grp", wr_grp_b, mgrp[1]);
            chk("b_frame_cnt", frame_cnt_b, mfc[1]);
            if (mcnt[1] > 0) chk("b_rd_data", rd_data_b, mfr[1][0]);
        end
    end

    function automatic logic [127:0] lanes4(input int base);
        logic [127:0] v;
        for (int i = 0; i < 4; i++) v[i*32 +: 32] = base + i;
        return v;
    endfunction

    function automatic logic [255:0] seq8(input int base);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = base + i;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input int base, input logic rr);
        wr_valid_a = 1'b1;
        wr_data_a  = lanes4(base);
        rd_ready_a = rr;
        cyc();
        wr_valid_a = 1'b0;
        rd_ready_a = 1'b0;
    endtask

    task automatic release_a();
        rd_ready_a = 1'b1;
        cyc();
        rd_ready_a = 1'b0;
    endtask

    initial begin
        // 1: reset, then one frame with the consumer stalled
        cyc();
        cyc();
        chk("rst_rd_valid", rd_valid_a, 1'b0);
        chk("rst_wr_ready", wr_ready_a, 1'b1);
        chk("rst_wr_grp", wr_grp_a, 1'b0);
        chk("rst_frame_cnt", frame_cnt_a, 16'd0);
        rst_n = 1'b1;
        cyc();
        beat_a(1, 1'b0);
        chk("t1_rd_valid_after_beat1", rd_valid_a, 1'b0);
        chk("t1_wr_grp_after_beat1", wr_grp_a, 1'b1);
        beat_a(5, 1'b0);
        chk("t1_rd_valid", rd_valid_a, 1'b1);
        chk("t1_rd_data", rd_data_a, seq8(1));
        chk("t1_frame_cnt", frame_cnt_a, 16'd1);
        chk("t1_wr_grp", wr_grp_a, 1'b0);
        chk("t1_wr_ready", wr_ready_a, 1'b1);

        // 2: second frame fills the other bank, then buffer is full
        beat_a(9, 1'b0);
        beat_a(13, 1'b0);
        chk("t2_wr_ready_full", wr_ready_a, 1'b0);
        chk("t2_rd_data_held", rd_data_a, seq8(1));
        beat_a(99, 1'b0);
        chk("t2_frame_cnt_no_overflow", frame_cnt_a, 16'd2);
        release_a();
        chk("t2_rd_valid", rd_valid_a, 1'b1);
        chk("t2_rd_data", rd_data_a, seq8(9));
        chk("t2_wr_ready", wr_ready_a, 1'b1);

        // 3: frame completion and read release on the same edge
        beat_a(17, 1'b0);
        beat_a(21, 1'b1);
        chk("t3_rd_valid", rd_valid_a, 1'b1);
        chk("t3_rd_data", rd_data_a, seq8(17));
        chk("t3_frame_cnt", frame_cnt_a, 16'd3);
        chk("t3_wr_ready", wr_ready_a, 1'b1);

        // 5: reset mid-frame with bank 1 full
        beat_a(25, 1'b0);
        beat_a(29, 1'b0);
        chk("t5_both_full", wr_ready_a, 1'b0);
        release_a();
        chk("t5_rd_data_bank1", rd_data_a, seq8(25));
        beat_a(33, 1'b0);
        chk("t5_wr_grp_mid", wr_grp_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t5_rd_valid", rd_valid_a, 1'b0);
        chk("t5_wr_ready", wr_ready_a, 1'b1);
        chk("t5_wr_grp", wr_grp_a, 1'b0);
        chk("t5_frame_cnt", frame_cnt_a, 16'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        beat_a(41, 1'b0);
        beat_a(45, 1'b0);
        chk("t5_post_rd_data", rd_data_a, seq8(41));
        chk("t5_post_frame_cnt", frame_cnt_a, 16'd1);
        release_a();
        chk("t5_post_empty", rd_valid_a, 1'b0);

`ifdef PINGPONG_VEC_BUF_FLUSH_EN
        // 6: flush abandons a partial frame
        beat_a(32'h300, 1'b0);
        flush_a    = 1'b1;
        wr_valid_a = 1'b1;
        wr_data_a  = lanes4(32'h400);
        #1;
        chk("t6_wr_ready_flush", wr_ready_a, 1'b0);
        cyc();
        flush_a    = 1'b0;
        wr_valid_a = 1'b0;
        chk("t6_wr_grp", wr_grp_a, 1'b0);
        beat_a(32'hA0, 1'b0);
        beat_a(32'hA4, 1'b0);
        chk("t6_rd_data", rd_data_a, seq8(32'hA0));
        chk("t6_frame_cnt", frame_cnt_a, 16'd2);
        release_a();
`endif

        // 4: single-group frames streamed with the consumer always ready
        rd_ready_b = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wr_valid_b = 1'b1;
            wr_data_b  = seq8(32'h100 + 8*k);
            cyc();
            chk("t4_rd_valid", rd_valid_b, 1'b1);
            chk("t4_rd_data", rd_data_b, seq8(32'h100 + 8*k));
            chk("t4_wr_ready", wr_ready_b, 1'b1);
        end
        chk("t4_frame_cnt", frame_cnt_b, 2'd3);
        wr_data_b = seq8(32'h200);
        cyc();
        wr_valid_b = 1'b0;
        chk("t4_frame_cnt_wrap", frame_cnt_b, 2'd0);
        chk("t4_rd_data_wrap", rd_data_b, seq8(32'h200));
        cyc();
        chk("t4_drained", rd_valid_b, 1'b0);
        rd_ready_b = 1'b0;
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
